// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, functs,
// ALUOp/ALU control codes and the per-state control word.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_IWB     = 4'd10,
    S_JUMP    = 4'd11,
    S_ORIEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // pc_fetch/pc_jump/pc_branch are qualifiers; the top combines them with
  // mem_ready and zero to form pc_en and ir_write.
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       pc_fetch;
    logic       pc_jump;
    logic       pc_branch;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = 2'b01;
        c.pc_fetch  = 1'b1;
      end
      S_DECODE:  c.alu_src_b = 2'b11;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        c.mem_req   = 1'b1;
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALUOP_SUB;
        c.pc_src    = 2'b01;
        c.pc_branch = 1'b1;
      end
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_ORIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = ALUOP_OR;
        c.imm_zext  = 1'b1;
      end
      S_IWB:     c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_src  = 2'b10;
        c.pc_jump = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU control decode: (ALUOp, funct) -> 3-bit ALU op, plus R-type funct legality.
module mc_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_valid
);

  always_comb begin
    funct_valid = 1'b0;
    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_valid = 1'b1;
      default:                               funct_valid = 1'b0;
    endcase
  end

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_OR:  alu_control = ALU_OR;
      default: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: Moore control word registered alongside the state,
// with mem_ready/zero/reset qualifying the enables that must react in-cycle.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter bit EN_BNE        = 1'b1,
  parameter bit EN_ORI        = 1'b1,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_zext,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic [2:0] alu_control,
  output logic       illegal_instr,
  output logic [3:0] state_o
);

  state_t state, state_nxt;
  ctrl_t  ctrl_q;
  logic   is_bne;
  logic   illegal;
  logic   funct_valid;
  logic   ready;

  assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

  mc_alu_decoder u_alu_dec (
    .alu_op      (ctrl_q.alu_op),
    .funct       (funct),
    .alu_control (alu_control),
    .funct_valid (funct_valid)
  );

  always_comb begin
    state_nxt = state;
    illegal   = 1'b0;
    case (state)
      S_FETCH:  if (ready) state_nxt = S_DECODE;
      S_DECODE: begin
        state_nxt = S_FETCH;
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE: begin
            if (funct_valid) state_nxt = S_EXECUTE;
            else             illegal   = 1'b1;
          end
          OP_BEQ:  state_nxt = S_BRANCH;
          OP_BNE: begin
            if (EN_BNE) state_nxt = S_BRANCH;
            else        illegal   = 1'b1;
          end
          OP_ADDI: state_nxt = S_ADDIEX;
          OP_ORI: begin
            if (EN_ORI) state_nxt = S_ORIEX;
            else        illegal   = 1'b1;
          end
          OP_J:    state_nxt = S_JUMP;
          default: illegal = 1'b1;
        endcase
      end
      S_MEMADR:  state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (ready) state_nxt = S_MEMWB;
      S_MEMWR:   if (ready) state_nxt = S_FETCH;
      S_EXECUTE: state_nxt = S_ALUWB;
      S_ADDIEX,
      S_ORIEX:   state_nxt = S_IWB;
      default:   state_nxt = S_FETCH;
    endcase
  end

  // Control word tracks the state it will describe, so it is valid the same
  // cycle the state register updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_FETCH;
      ctrl_q <= state_ctrl(S_FETCH);
      is_bne <= 1'b0;
    end else begin
      state  <= state_nxt;
      ctrl_q <= state_ctrl(state_nxt);
      if (state == S_DECODE) is_bne <= (opcode == OP_BNE);
    end
  end

  assign mem_req       = ctrl_q.mem_req   & ~reset;
  assign mem_write     = ctrl_q.mem_write & ~reset;
  assign reg_write     = ctrl_q.reg_write & ~reset;
  assign ir_write      = ctrl_q.pc_fetch & ready & ~reset;
  assign pc_en         = ~reset & ((ctrl_q.pc_fetch & ready) | ctrl_q.pc_jump |
                                   (ctrl_q.pc_branch & (zero ^ is_bne)));
  assign illegal_instr = illegal & ~reset;

  assign iord       = ctrl_q.iord;
  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign imm_zext   = ctrl_q.imm_zext;
  assign pc_src     = ctrl_q.pc_src;
  assign state_o    = state;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised multicycle successor to the single-cycle `controller`: a Moore FSM that sequences fetch, decode, execute, memory and writeback over several clocks.
- Drives datapath muxes, enables and ALU control, and handshakes with a shared instruction/data memory through mem_req/mem_ready.
- Adds optional bne and ori support, wait-state stalling, and illegal-instruction flagging.
- Sits between the instruction register and the multicycle datapath.

Parameters:
- EN_BNE, 1: decode opcode 000101 (bne); when 0, bne is treated as illegal.
- EN_ORI, 1: decode opcode 001101 (ori, zero-extended immediate); when 0, ori is treated as illegal.
- MEM_HANDSHAKE, 1: honour mem_ready; when 0, mem_ready is internally tied to 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access active (FETCH, MEMRD, MEMWR)
- iord  out  1  0 = PC address, 1 = ALUOut address
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = data register, 0 = ALUOut
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = 4, 10 = immediate, 11 = immediate<<2
- imm_zext  out  1  zero-extend the immediate (ori)
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- pc_en  out  1  PC load enable
- alu_control  out  3  ALU operation
- illegal_instr  out  1  one-cycle pulse in DECODE on an unsupported opcode or funct
- state_o  out  4  current state encoding, for debug and verification

Behaviour:
- FSM states (encoding 0–12): FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, IWB, JUMP, ORIEX. All outputs are decoded from state (Moore), except where stated below.
- Reset:
  - On a clock edge with reset=1, state goes to FETCH.
  - While reset=1, the following are forced 0 combinationally: pc_en, ir_write, reg_write, mem_write, mem_req, illegal_instr.
  - Reset mid-instruction abandons the instruction; no partial writeback.
- FETCH:
  - mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, ALUOp=00, pc_src=00.
  - ir_write and pc_en are asserted only when mem_ready=1; the FSM then moves to DECODE. Otherwise it stays in FETCH.
- DECODE:
  - alu_src_b=11, ALUOp=00.
  - Next state by opcode: 100011 and 101011 -> MEMADR; 000000 -> EXECUTE; 000100, and 000101 if EN_BNE -> BRANCH; 001000 -> ADDIEX; 001101 if EN_ORI -> ORIEX; 000010 -> JUMP.
  - Any other opcode, or an R-type funct outside {100000, 100010, 100100, 100101, 101010}: illegal_instr=1 for this cycle only, next state FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, ALUOp=00. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Stays until mem_ready=1, then MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1 for exactly one cycle, then FETCH.
- MEMWR: mem_req=1, iord=1, mem_write=1, held until mem_ready=1, then FETCH.
- EXECUTE -> ALUWB:
  - EXECUTE: alu_src_a=1, alu_src_b=00, ALUOp=10.
  - ALUWB: reg_dst=1, reg_write=1, then FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, ALUOp=01, pc_src=01.
  - pc_en = zero for beq, ~zero for bne (combinational on zero). Next state FETCH.
  - The opcode is latched in a 1-bit is_bne register in DECODE.
- ADDIEX / ORIEX:
  - alu_src_a=1, alu_src_b=10. ADDIEX uses ALUOp=00; ORIEX uses ALUOp=11 and imm_zext=1.
  - Both go to IWB: reg_dst=0, mem_to_reg=0, reg_write=1, then FETCH.
- JUMP: pc_src=10, pc_en=1, then FETCH.
- ALU decode:
  - ALUOp 00 -> 010; 01 -> 110; 11 -> 001.
  - ALUOp 10 by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, other -> 010.
- Latency with mem_ready=1 throughout: lw 5 cycles; sw, R-type, addi, ori 4 cycles; beq, bne, j 3 cycles. Each mem_ready=0 cycle adds exactly one cycle.
- Unlisted outputs are 0 in every state.

Decomposition:
- Package `mips_ctrl_pkg`:
  - state_t enum (4-bit);
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J;
  - funct constants;
  - ALUOp encodings;
  - ALU control constants.
- One sub-module, `mc_alu_decoder`: combinational (ALUOp, funct) -> alu_control, plus a funct_valid output.

Test Plan:
- lw (opcode 100011), mem_ready=1 -> state_o sequence 0,1,2,3,4,0; reg_write=1 only in MEMWB with mem_to_reg=1; 5 cycles total.
- sw with mem_ready held 0 for 3 cycles in MEMWR -> mem_write=1 for 4 consecutive cycles, reg_write never 1, returns to FETCH.
- beq: zero=1 -> pc_en=1 in BRANCH with pc_src=01. bne: zero=1 -> pc_en=0; bne with zero=0 -> pc_en=1. alu_control=110 in both.
- R-type funct 101010 -> alu_control=111 in EXECUTE, reg_dst=1 and reg_write=1 in ALUWB. funct 000111 -> illegal_instr pulses 1 cycle in DECODE, no reg_write.
- ori with EN_ORI=1 -> imm_zext=1 and alu_control=001 in ORIEX, then IWB. Rebuild with EN_ORI=0 -> illegal_instr, FETCH.
- Reset asserted in MEMRD -> next edge state_o=0, no reg_write. FETCH with mem_ready=0 for 2 cycles -> ir_write and pc_en stay 0 until mem_ready=1.
